// File: rtl/registro_puntaje_multi_if.sv
// registro_puntaje_multi_if: game-side and display-side signals of the multi-column score register
// master: drives start, game_over and puntos, observes the score outputs
// slave : the score register itself
interface registro_puntaje_multi_if #(
    parameter int N_COL   = 5,
    parameter int PTS_W   = 2,
    parameter int SCORE_W = 10,
    parameter int LEVEL_W = 4
);
    logic                     start;
    logic                     game_over;
    logic [N_COL*PTS_W-1:0]   puntos;
    logic [SCORE_W-1:0]       puntaje;
    logic [SCORE_W-1:0]       record;
    logic [LEVEL_W-1:0]       nivel;
    logic                     nuevo_record;
    logic                     pulso_sonido;
    logic                     jugando;

    modport master (
        output start, game_over, puntos,
        input  puntaje, record, nivel, nuevo_record, pulso_sonido, jugando
    );

    modport slave (
        input  start, game_over, puntos,
        output puntaje, record, nivel, nuevo_record, pulso_sonido, jugando
    );
endinterface

// File: rtl/registro_puntaje_multi.sv
// registro_puntaje_multi: saturating multi-column score, level, record and sound-pulse register
// clk   : rising-edge clock
// reset : asynchronous, active-low
// bus   : slave side of registro_puntaje_multi_if
//         in : start, game_over, puntos (column c at [c*PTS_W +: PTS_W])
//         out: puntaje, record, nivel, nuevo_record, pulso_sonido, jugando (all registered)
module registro_puntaje_multi #(
    parameter int N_COL      = 5,
    parameter int PTS_W      = 2,
    parameter int SCORE_W    = 10,
    parameter int LEVEL_W    = 4,
    parameter int LEVEL_STEP = 50,
    parameter int PULSE_LEN  = 4
) (
    input logic                    clk,
    input logic                    reset,
    registro_puntaje_multi_if.slave bus
);
    // SUM_W holds N_COL*(2**PTS_W-1) without overflow
    localparam int SUM_W  = PTS_W + $clog2(N_COL + 1);
    localparam int PROG_W = $clog2(LEVEL_STEP + 1);
    localparam int PS_W   = PROG_W + SUM_W;
    localparam int CNT_W  = $clog2(PULSE_LEN + 1);

    typedef enum logic [1:0] {IDLE, JUEGO, FIN} state_t;

    state_t                 state;
    logic [SCORE_W-1:0]     puntaje_q, record_q, f;
    logic [LEVEL_W-1:0]     nivel_q;
    logic [PROG_W-1:0]      progreso, prog_next;
    logic [CNT_W-1:0]       cnt;
    logic                   nuevo_q, pulso_q, jugando_q, lvl_up;
    logic [SUM_W-1:0]       s;
    logic [SCORE_W+SUM_W-1:0] score_sum;
    logic [PS_W-1:0]        prog_sum;

    always_comb begin
        s = '0;
        for (int c = 0; c < N_COL; c++)
            s = s + SUM_W'(bus.puntos[c*PTS_W +: PTS_W]);
        score_sum = (SCORE_W+SUM_W)'(puntaje_q) + (SCORE_W+SUM_W)'(s);
        // any carry beyond SCORE_W means the score saturates
        f = (score_sum[SCORE_W +: SUM_W] != '0) ? '1 : score_sum[SCORE_W-1:0];
        prog_sum = PS_W'(progreso) + PS_W'(s);
        lvl_up = prog_sum >= PS_W'(LEVEL_STEP);
        prog_next = lvl_up ? PROG_W'(prog_sum - PS_W'(LEVEL_STEP)) : PROG_W'(prog_sum);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            puntaje_q <= '0;
            record_q  <= '0;
            nivel_q   <= '0;
            progreso  <= '0;
            cnt       <= '0;
            nuevo_q   <= 1'b0;
            pulso_q   <= 1'b0;
            jugando_q <= 1'b0;
        end else begin
            nuevo_q <= 1'b0;
            // pulso_q mirrors "counter was non-zero", so a load of PULSE_LEN-1 yields PULSE_LEN high cycles
            if (cnt != '0) begin
                cnt     <= cnt - CNT_W'(1);
                pulso_q <= 1'b1;
            end else begin
                pulso_q <= 1'b0;
            end
            if (bus.start) begin
                state     <= JUEGO;
                jugando_q <= 1'b1;
                puntaje_q <= '0;
                nivel_q   <= '0;
                progreso  <= '0;
                cnt       <= '0;
                pulso_q   <= 1'b0;
            end else if (state == JUEGO) begin
                puntaje_q <= f;
                progreso  <= prog_next;
                if (lvl_up && nivel_q != '1)
                    nivel_q <= nivel_q + LEVEL_W'(1);
                if (s != '0) begin
                    cnt     <= CNT_W'(PULSE_LEN - 1);
                    pulso_q <= 1'b1;
                end
                if (bus.game_over) begin
                    state     <= FIN;
                    jugando_q <= 1'b0;
                    if (f > record_q) begin
                        record_q <= f;
                        nuevo_q  <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.puntaje      = puntaje_q;
    assign bus.record       = record_q;
    assign bus.nivel        = nivel_q;
    assign bus.nuevo_record = nuevo_q;
    assign bus.pulso_sonido = pulso_q;
    assign bus.jugando      = jugando_q;
endmodule

// File: tb/tb_registro_puntaje_multi.sv
// tb_registro_puntaje_multi: directed scoreboard bench for registro_puntaje_multi
module tb_registro_puntaje_multi;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    typedef struct {
        string tag;
        int    pj, rec, niv, nr, ps, jug;
    } exp_t;

    exp_t sb[$];

    registro_puntaje_multi_if bus ();

    registro_puntaje_multi dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] pk(input int a, input int b, input int c, input int d, input int e);
        return {2'(e), 2'(d), 2'(c), 2'(b), 2'(a)};
    endfunction

    task automatic cmp(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] want);
        compared++;
        assert (obs === want) else begin
            mismatched++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, want);
        end
    endtask

    task automatic push(input string tag, input int pj, input int rec, input int niv,
                        input int nr, input int ps, input int jug);
        exp_t e;
        e.tag = tag; e.pj = pj; e.rec = rec; e.niv = niv; e.nr = nr; e.ps = ps; e.jug = jug;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        cmp(e.tag, "puntaje",      32'(bus.puntaje),      e.pj);
        cmp(e.tag, "record",       32'(bus.record),       e.rec);
        cmp(e.tag, "nivel",        32'(bus.nivel),        e.niv);
        cmp(e.tag, "nuevo_record", 32'(bus.nuevo_record), e.nr);
        cmp(e.tag, "pulso_sonido", 32'(bus.pulso_sonido), e.ps);
        cmp(e.tag, "jugando",      32'(bus.jugando),      e.jug);
    endtask

    // expectation is queued when the stimulus is driven, checked #1 after the sampling edge
    task automatic step(input string tag, input logic st, input logic go, input logic [9:0] p,
                        input int pj, input int rec, input int niv, input int nr, input int ps, input int jug);
        push(tag, pj, rec, niv, nr, ps, jug);
        bus.start = st;
        bus.game_over = go;
        bus.puntos = p;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.game_over = 1'b0;
        bus.puntos = '0;
        pop_check();
    endtask

    initial begin
        logic [9:0] p15;
        p15 = pk(3, 3, 3, 3, 3);
        bus.start = 1'b0;
        bus.game_over = 1'b0;
        bus.puntos = '0;
        #1 reset = 1'b0;
        #2;
        push("reset", 0, 0, 0, 0, 0, 0);
        pop_check();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step("idle_pts", 0, 0, p15, 0, 0, 0, 0, 0, 0);
        step("idle_go",  0, 1, '0,  0, 0, 0, 0, 0, 0);
        step("t1_start", 1, 0, '0,  0, 0, 0, 0, 0, 1);
        step("t1_hit",   0, 0, pk(1, 2, 3, 0, 1), 7, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++)
            step("t1_hold", 0, 0, '0, 7, 0, 0, 0, 1, 1);
        step("t1_off",   0, 0, '0, 7, 0, 0, 0, 0, 1);
        step("t4_hit_a", 0, 0, pk(1, 0, 0, 0, 0), 8, 0, 0, 0, 1, 1);
        step("t4_gap",   0, 0, '0, 8, 0, 0, 0, 1, 1);
        step("t4_hit_b", 0, 0, pk(1, 0, 0, 0, 0), 9, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++)
            step("t4_hold", 0, 0, '0, 9, 0, 0, 0, 1, 1);
        step("t4_off",   0, 0, '0, 9, 0, 0, 0, 0, 1);
        step("g1_a",     0, 0, p15, 24, 0, 0, 0, 1, 1);
        step("g1_end",   0, 1, pk(3, 3, 0, 0, 0), 30, 30, 0, 1, 1, 0);
        step("fin_pts",  0, 0, p15, 30, 30, 0, 0, 1, 0);
        step("fin_go",   0, 1, '0,  30, 30, 0, 0, 1, 0);
        step("g2_start", 1, 0, '0,  0, 30, 0, 0, 0, 1);
        step("g2_a",     0, 0, p15, 15, 30, 0, 0, 1, 1);
        step("g2_end",   0, 1, p15, 30, 30, 0, 0, 1, 0);
        step("g2_after", 0, 0, '0,  30, 30, 0, 0, 1, 0);
        step("g3_start", 1, 0, '0,  0, 30, 0, 0, 0, 1);
        step("g3_a",     0, 0, p15, 15, 30, 0, 0, 1, 1);
        step("g3_b",     0, 0, p15, 30, 30, 0, 0, 1, 1);
        step("g3_end",   0, 1, pk(1, 0, 0, 0, 0), 31, 31, 0, 1, 1, 0);
        step("g3_after", 0, 0, '0,  31, 31, 0, 0, 1, 0);
        step("t3_start", 1, 0, '0,  0, 31, 0, 0, 0, 1);
        step("t3_15",    0, 0, p15, 15, 31, 0, 0, 1, 1);
        step("t3_30",    0, 0, p15, 30, 31, 0, 0, 1, 1);
        step("t3_45",    0, 0, p15, 45, 31, 0, 0, 1, 1);
        step("t3_60",    0, 0, p15, 60, 31, 1, 0, 1, 1);
        step("t3_75",    0, 0, p15, 75, 31, 1, 0, 1, 1);
        step("t3_90",    0, 0, p15, 90, 31, 1, 0, 1, 1);
        step("t3_100",   0, 0, pk(3, 3, 3, 1, 0), 100, 31, 2, 0, 1, 1);
        step("t6_both",  1, 1, p15, 0, 31, 0, 0, 0, 1);
        step("t2_start", 1, 0, '0,  0, 31, 0, 0, 0, 1);
        for (int n = 1; n <= 68; n++)
            step("t2_ramp", 0, 0, p15, 15 * n, 31, ((15 * n) / 50 > 15) ? 15 : (15 * n) / 50, 0, 1, 1);
        step("t2_sat9",  0, 0, pk(3, 3, 3, 0, 0), 1023, 31, 15, 0, 1, 1);
        step("t2_sat3",  0, 0, pk(3, 0, 0, 0, 0), 1023, 31, 15, 0, 1, 1);
        step("t2_go",    0, 1, '0,  1023, 1023, 15, 1, 1, 0);
        step("t6_finpt", 0, 0, p15, 1023, 1023, 15, 0, 1, 0);
        step("t6_restart", 1, 0, '0, 0, 1023, 0, 0, 0, 1);
        step("t6_hit",   0, 0, p15, 15, 1023, 0, 0, 1, 1);
        reset = 1'b0;
        #2;
        push("async_rst", 0, 0, 0, 0, 0, 0);
        pop_check();
        @(negedge clk);
        reset = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
